// File: rtl/pa_operand_streamer.sv
// pa_operand_streamer: memory-side partner of the processing-array sequencer.
// Prefetches weight and activation words from SRAM into two small FIFOs that
// feed the weight_rd/data_rd handshakes, and writes dst_wr results back to SRAM.
// Optional macro PA_STREAM_PERF_EN builds the starved-acquire cycle counter;
// when it is undefined stall_cycles is tied to zero.

// Small prefetch FIFO used once per read stream. Storage is not reset;
// occupancy and pointers are. The head is forced to zero when empty so the
// stream data outputs read as zero after reset and between words.
module pa_stream_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Storage write; the caller only pushes into a slot it reserved earlier.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = empty ? '0 : mem[rd_ptr_reg];
endmodule

module pa_operand_streamer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [31:0]       weight_len,
  input  logic [ADDR_W-1:0] data_base,
  input  logic [31:0]       data_len,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [31:0]       dst_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              weight_rd_rdy,
  input  logic              weight_rd_acq,
  output logic [DATA_W-1:0] weight_data,
  output logic              data_rd_rdy,
  input  logic              data_rd_acq,
  output logic [DATA_W-1:0] data_out,
  input  logic              dst_wr_rdy,
  output logic              dst_wr_acq,
  input  logic [DATA_W-1:0] dst_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] w_base_reg, d_base_reg, o_base_reg;
  logic [31:0]       w_len_reg, d_len_reg, o_len_reg;
  logic [31:0]       w_issued_reg, d_issued_reg;
  logic [31:0]       w_popped_reg, d_popped_reg;
  logic [31:0]       written_reg;
  // One-deep record of the read in flight: valid and which stream issued it.
  logic              pend_vld_reg;
  logic              pend_sel_reg;

  logic              run;
  logic              w_inflight, d_inflight;
  logic [CW-1:0]     w_count, d_count;
  logic              w_empty, d_empty;
  logic              w_elig, d_elig;
  logic              issue_w, issue_d;
  logic              w_push, d_push;
  logic              w_pop, d_pop;
  logic              wr_fire;
  logic              all_done;

  assign run        = (state_reg == ST_RUN);
  assign w_inflight = pend_vld_reg & ~pend_sel_reg;
  assign d_inflight = pend_vld_reg &  pend_sel_reg;

  // Eligibility counts the in-flight read as occupied, so a returning word
  // always has a free slot and the FIFO can never overflow.
  assign w_elig  = run && (w_issued_reg < w_len_reg) &&
                   ((w_count + {{(CW-1){1'b0}}, w_inflight}) < DEPTH_C);
  assign d_elig  = run && (d_issued_reg < d_len_reg) &&
                   ((d_count + {{(CW-1){1'b0}}, d_inflight}) < DEPTH_C);
  assign issue_w = w_elig;
  assign issue_d = d_elig & ~w_elig;

  assign mem_rd_en   = issue_w | issue_d;
  assign mem_rd_addr = issue_w ? (w_base_reg + w_issued_reg[ADDR_W-1:0]) :
                       issue_d ? (d_base_reg + d_issued_reg[ADDR_W-1:0]) : '0;

  assign w_push = w_inflight;
  assign d_push = d_inflight;

  assign weight_rd_rdy = ~w_empty;
  assign data_rd_rdy   = ~d_empty;
  assign w_pop         = weight_rd_rdy & weight_rd_acq;
  assign d_pop         = data_rd_rdy & data_rd_acq;

  assign dst_wr_acq  = run && (written_reg < o_len_reg);
  assign wr_fire     = dst_wr_rdy & dst_wr_acq;
  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wr_fire ? (o_base_reg + written_reg[ADDR_W-1:0]) : '0;
  assign mem_wr_data = wr_fire ? dst_data : '0;

  assign all_done = (w_popped_reg == w_len_reg) && (d_popped_reg == d_len_reg) &&
                    (written_reg == o_len_reg);

  assign busy = run;
  assign done = (state_reg == ST_DONE);

  pa_stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (mem_rd_data),
    .pop       (w_pop),
    .head      (weight_data),
    .empty     (w_empty),
    .count     (w_count)
  );

  pa_stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_d_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (d_push),
    .push_data (mem_rd_data),
    .pop       (d_pop),
    .head      (data_out),
    .empty     (d_empty),
    .count     (d_count)
  );

  // Job FSM with region registers, progress counters and the in-flight read record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      w_base_reg   <= '0;
      d_base_reg   <= '0;
      o_base_reg   <= '0;
      w_len_reg    <= '0;
      d_len_reg    <= '0;
      o_len_reg    <= '0;
      w_issued_reg <= '0;
      d_issued_reg <= '0;
      w_popped_reg <= '0;
      d_popped_reg <= '0;
      written_reg  <= '0;
      pend_vld_reg <= 1'b0;
      pend_sel_reg <= 1'b0;
    end else begin
      pend_vld_reg <= mem_rd_en;
      pend_sel_reg <= issue_d;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            w_base_reg   <= weight_base;
            d_base_reg   <= data_base;
            o_base_reg   <= dst_base;
            w_len_reg    <= weight_len;
            d_len_reg    <= data_len;
            o_len_reg    <= dst_len;
            w_issued_reg <= '0;
            d_issued_reg <= '0;
            w_popped_reg <= '0;
            d_popped_reg <= '0;
            written_reg  <= '0;
            state_reg    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue_w) w_issued_reg <= w_issued_reg + 32'd1;
          if (issue_d) d_issued_reg <= d_issued_reg + 32'd1;
          if (w_pop)   w_popped_reg <= w_popped_reg + 32'd1;
          if (d_pop)   d_popped_reg <= d_popped_reg + 32'd1;
          if (wr_fire) written_reg  <= written_reg + 32'd1;
          if (all_done) state_reg <= ST_DONE;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef PA_STREAM_PERF_EN
  logic [31:0] stall_reg;
  logic        stall_hit;

  assign stall_hit = run & ((weight_rd_acq & ~weight_rd_rdy) | (data_rd_acq & ~data_rd_rdy));

  // Saturating count of RUN cycles where the sequencer asked for a word that was not there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      stall_reg <= '0;
    end else if (stall_hit && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pa_operand_streamer.sv
// Self-checking bench for pa_operand_streamer: table of jobs run through a
// scoreboard (expected read words, read addresses and writes queued when the
// job is set up or stimulus is driven), plus a hand-written mid-job reset.
module tb_pa_operand_streamer;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] weight_base, data_base, dst_base;
  logic [31:0]   weight_len, data_len, dst_len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          weight_rd_rdy, weight_rd_acq;
  logic [DW-1:0] weight_data;
  logic          data_rd_rdy, data_rd_acq;
  logic [DW-1:0] data_out;
  logic          dst_wr_rdy, dst_wr_acq;
  logic [DW-1:0] dst_data;
  logic          busy, done;
  logic [31:0]   stall_cycles;

  always #5 clk = ~clk;

  pa_operand_streamer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .weight_base(weight_base), .weight_len(weight_len),
    .data_base(data_base), .data_len(data_len),
    .dst_base(dst_base), .dst_len(dst_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .weight_rd_rdy(weight_rd_rdy), .weight_rd_acq(weight_rd_acq), .weight_data(weight_data),
    .data_rd_rdy(data_rd_rdy), .data_rd_acq(data_rd_acq), .data_out(data_out),
    .dst_wr_rdy(dst_wr_rdy), .dst_wr_acq(dst_wr_acq), .dst_data(dst_data),
    .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );

  // SRAM contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // One-cycle read latency; junk on cycles without a read exposes timing slips.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
    else           mem_rd_data <= $urandom();
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] wb; int wl;
    logic [15:0] db; int dl;
    logic [15:0] ob; int ol;
    int d_delay;      // data acq held low for this many RUN cycles
    bit rnd;          // random acq pattern
    int wr_gap;       // offer a result word every wr_gap cycles
    int exp_first;    // cycle of first rdy (-1: not checked)
    int exp_done;     // cycle of done pulse (-1: not checked)
    int exp_stall_rd; // reads issued while data acq held low (-1: not checked)
    bit exp_wfirst;   // all weight reads precede any data read
  } vec_t;

  logic [31:0] w_q[$];
  logic [31:0] d_q[$];
  logic [15:0] wa_q[$];
  logic [15:0] da_q[$];
  logic [47:0] wr_q[$];

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_wrdy"},     weight_rd_rdy, 0);
    chk({tag, "_drdy"},     data_rd_rdy, 0);
    chk({tag, "_rd_en"},    mem_rd_en, 0);
    chk({tag, "_rd_addr"},  mem_rd_addr, 0);
    chk({tag, "_wr_en"},    mem_wr_en, 0);
    chk({tag, "_wacq"},     dst_wr_acq, 0);
    chk({tag, "_wdata"},    weight_data, 0);
    chk({tag, "_dout"},     data_out, 0);
    chk({tag, "_stall"},    stall_cycles, 0);
  endtask

  // Runs one job from IDLE; caller is at posedge+1.
  task automatic run_job(input vec_t v, input string tag);
    int cyc = 0, w_taken = 0, d_taken = 0, sent = 0, written = 0;
    int stall_rd = 0, first_rdy = -1, first_x = -1, last_x = -1, n_x = 0;
    int stall_model = 0, n_reads = 0, done_cyc = -1;
    bit seen_done = 0, wfirst_ok = 1, matched;
    logic [15:0] a;
    logic [47:0] e;
    for (int i = 0; i < v.wl; i++) begin
      a = v.wb + 16'(i); wa_q.push_back(a); w_q.push_back(mem_word(a));
    end
    for (int i = 0; i < v.dl; i++) begin
      a = v.db + 16'(i); da_q.push_back(a); d_q.push_back(mem_word(a));
    end
    weight_base = v.wb; weight_len = 32'(v.wl);
    data_base   = v.db; data_len   = 32'(v.dl);
    dst_base    = v.ob; dst_len    = 32'(v.ol);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen_done && cyc < 300) begin
      weight_rd_acq = (w_taken < v.wl) && (!v.rnd || $urandom_range(0, 1) == 1);
      data_rd_acq   = (d_taken < v.dl) && (cyc >= v.d_delay) &&
                      (!v.rnd || $urandom_range(0, 1) == 1);
      if (sent < v.ol && (cyc % v.wr_gap) == 0) begin
        dst_wr_rdy = 1'b1;
        dst_data   = 32'hA + 32'(sent);
        e = {16'(v.ob + 16'(sent)), dst_data};
        wr_q.push_back(e);
        sent++;
      end else begin
        dst_wr_rdy = 1'b0;
        dst_data   = $urandom();
      end
      @(negedge clk);
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_wacq_at_done"}, dst_wr_acq, 0);
`ifdef PA_STREAM_PERF_EN
        chk({tag, "_stall_cycles"}, stall_cycles, stall_model);
`else
        chk({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
      end else begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_dst_wr_acq"}, dst_wr_acq, (written < v.ol) ? 1 : 0);
        if ((weight_rd_acq && !weight_rd_rdy) || (data_rd_acq && !data_rd_rdy)) stall_model++;
      end
      if (first_rdy < 0 && (weight_rd_rdy || data_rd_rdy)) first_rdy = cyc;
      if (mem_rd_en) begin
        n_reads++;
        if (cyc < v.d_delay) stall_rd++;
        matched = 0;
        if (wa_q.size() > 0 && mem_rd_addr == wa_q[0]) begin
          void'(wa_q.pop_front()); matched = 1;
        end else if (da_q.size() > 0 && mem_rd_addr == da_q[0]) begin
          void'(da_q.pop_front()); matched = 1;
          if (wa_q.size() > 0) wfirst_ok = 0;
        end
        chk({tag, "_rd_addr_expected"}, matched, 1);
      end
      if (weight_rd_rdy && weight_rd_acq) begin
        if (w_q.size() > 0) chk({tag, "_weight_data"}, weight_data, w_q.pop_front());
        else chk({tag, "_weight_extra"}, 1, 0);
        w_taken++; n_x++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (data_rd_rdy && data_rd_acq) begin
        if (d_q.size() > 0) chk({tag, "_data_out"}, data_out, d_q.pop_front());
        else chk({tag, "_data_extra"}, 1, 0);
        d_taken++; n_x++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (mem_wr_en) begin
        if (wr_q.size() > 0) chk({tag, "_mem_wr"}, {mem_wr_addr, mem_wr_data}, wr_q.pop_front());
        else chk({tag, "_wr_extra"}, 1, 0);
        written++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_seen"}, seen_done, 1);
    if (v.exp_done >= 0) chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
    if (v.exp_first >= 0) chk({tag, "_first_rdy"}, first_rdy, v.exp_first);
    if (n_x > 0 && !v.rnd) chk({tag, "_gapless"}, last_x - first_x + 1, n_x);
    if (v.exp_stall_rd >= 0) chk({tag, "_stalled_reads"}, stall_rd, v.exp_stall_rd);
    if (v.exp_wfirst) chk({tag, "_weights_first"}, wfirst_ok, 1);
    chk({tag, "_w_left"},  w_q.size() + wa_q.size(), 0);
    chk({tag, "_d_left"},  d_q.size() + da_q.size(), 0);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
    weight_rd_acq = 1'b0; data_rd_acq = 1'b0; dst_wr_rdy = 1'b0;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    $display("job %s: reads=%0d xfers=%0d writes=%0d done@%0d stall_model=%0d",
             tag, n_reads, n_x, written, done_cyc, stall_model);
    @(posedge clk); #1;
    w_q.delete(); d_q.delete(); wa_q.delete(); da_q.delete(); wr_q.delete();
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    weight_base = '0; data_base = '0; dst_base = '0;
    weight_len = '0; data_len = '0; dst_len = '0;
    weight_rd_acq = 1'b0; data_rd_acq = 1'b0; dst_wr_rdy = 1'b0; dst_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;

    //         wb       wl  db       dl  ob       ol dly rnd gap first done stall wfirst
    vecs[0] = '{16'h0100, 8, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 2, 11, -1, 0};
    vecs[1] = '{16'h0200, 4, 16'h0300, 4, 16'h0000, 0, 0, 0, 1, 2, 11, -1, 1};
    vecs[2] = '{16'h0000, 0, 16'h0400,10, 16'h0000, 0,20, 0, 1, 2, 31,  4, 0};
    vecs[3] = '{16'h0000, 0, 16'h0000, 0, 16'hFFFE, 4, 0, 0, 2,-1,  8, -1, 0};
    vecs[4] = '{16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1,-1,  1, -1, 0};
    vecs[5] = '{16'hFFFD, 5, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 2,  8, -1, 0};
    vecs[6] = '{16'h1000, 7, 16'h2000, 6, 16'h3000, 5, 0, 1, 3,-1, -1, -1, 0};
    vecs[7] = '{16'h5000, 3, 16'h6000, 3, 16'h7000, 2, 0, 0, 1, 2,  9, -1, 1};

    for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Mid-job reset with FIFOs partly filled and a read in flight.
    weight_base = 16'h0800; weight_len = 32'd8;
    data_base   = 16'h0900; data_len   = 32'd8;
    dst_base    = 16'h0A00; dst_len    = 32'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    weight_rd_acq = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    weight_rd_acq = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_no_read", mem_rd_en, 0);
    end
    @(posedge clk); #1;
    rv = '{16'h0800, 8, 16'h0900, 8, 16'h0A00, 2, 0, 0, 1, 2, -1, -1, 1};
    run_job(rv, "restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
